prog_clk_div: RTL and testbench



---
 rtl/prog_clk_div_pkg.sv | 14 +
 rtl/prog_clk_div_chan.sv | 70 +++++++
 rtl/prog_clk_div.sv | 55 +++++
 tb/tb_prog_clk_div.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clk_div_pkg.sv
// Shared constants and config layout for the programmable clock divider.
package prog_clk_div_pkg;

    localparam int CFG_WIDTH      = 8;
    localparam int DEFAULT_PERIOD = 2;
    localparam int DEFAULT_HIGH   = 1;
    localparam int MIN_PERIOD     = 2;

    typedef struct packed {
        logic [CFG_WIDTH-1:0] period;
        logic [CFG_WIDTH-1:0] high;
    } div_cfg_t;

endpackage

// File: rtl/prog_clk_div_chan.sv
// One divider channel: active/shadow config, counter and registered output.
// Tick edge detector is built only when PROG_CLK_DIV_TICK_EN is defined.
module prog_clk_div_chan
    import prog_clk_div_pkg::*;
#(
    parameter int WIDTH = CFG_WIDTH
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cfg_write,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             pending,
    output logic             clock_out,
    output logic             tick
);

    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] act_high;
    logic [WIDTH-1:0] sh_period;
    logic [WIDTH-1:0] sh_high;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             clock_next;
    logic             apply;

    assign wrap       = (count == act_period - WIDTH'(1));
    assign clock_next = enable && (count < act_high);
    // Shadow moves to active only at a period boundary or while stopped.
    assign apply      = pending && (!enable || wrap);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            act_period <= WIDTH'(DEFAULT_PERIOD);
            act_high   <= WIDTH'(DEFAULT_HIGH);
            sh_period  <= WIDTH'(DEFAULT_PERIOD);
            sh_high    <= WIDTH'(DEFAULT_HIGH);
            pending    <= 1'b0;
            count      <= '0;
            clock_out  <= 1'b0;
        end else begin
            clock_out <= clock_next;
            count     <= (!enable || wrap) ? '0 : count + WIDTH'(1);
            if (apply) begin
                act_period <= sh_period;
                act_high   <= sh_high;
                pending    <= 1'b0;
            end
            if (cfg_write) begin
                sh_period <= (cfg_period < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : cfg_period;
                sh_high   <= cfg_high;
                pending   <= 1'b1;
            end
        end
    end

`ifdef PROG_CLK_DIV_TICK_EN
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            tick <= 1'b0;
        end else begin
            tick <= clock_next & ~clock_out;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel runtime-programmable clock divider top.
// Define PROG_CLK_DIV_TICK_EN to build the per-channel tick outputs.
module prog_clk_div
    import prog_clk_div_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = CFG_WIDTH,
    localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] cfg_write;

    // Handshake: a write transfers on an edge with cfg_valid && cfg_ready;
    // ready is low only while the addressed channel holds an unapplied shadow.
    // Out-of-range channel indices are always ready and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        cfg_write = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CHAN_W'(i)) begin
                cfg_ready    = ~pending[i];
                cfg_write[i] = cfg_valid & ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        prog_clk_div_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clock_in  (clock_in),
            .reset_n   (reset_n),
            .enable    (enable[g]),
            .cfg_write (cfg_write[g]),
            .cfg_period(cfg_period),
            .cfg_high  (cfg_high),
            .pending   (pending[g]),
            .clock_out (clock_out[g]),
            .tick      (tick[g])
        );
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: waveform-queue reference model plus
// directed test-plan sequences and randomized traffic.
module tb_prog_clk_div;

    localparam int CH = 4;
    localparam int W  = 8;

    logic          clock_in;
    logic          reset_n;
    logic [CH-1:0] enable;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [W-1:0]  cfg_period;
    logic [W-1:0]  cfg_high;
    logic [CH-1:0] clock_out;
    logic [CH-1:0] tick;

    prog_clk_div #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .clock_out (clock_out),
        .tick      (tick)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each running channel plays out whole periods from a
    // queue of output bits; a new period is drawn from the active config.
    logic [W-1:0]    m_ap[CH];
    logic [W-1:0]    m_ah[CH];
    logic [W-1:0]    m_sp[CH];
    logic [W-1:0]    m_sh[CH];
    logic            m_pend[CH];
    logic            m_prev[CH];
    logic            wave_q[CH][$];
    logic [2*CH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_ap[i] = 2; m_ah[i] = 1; m_sp[i] = 2; m_sh[i] = 1;
            m_pend[i] = 1'b0; m_prev[i] = 1'b0;
            wave_q[i].delete();
        end
        exp_q.delete();
    endtask

    function automatic logic model_ready(input int ch);
        return (ch >= CH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic model_edge(input logic [CH-1:0] en, input logic v, input int ch,
                              input int p, input int h);
        logic [CH-1:0] o;
        logic [CH-1:0] t;
        logic          acc;
        acc = v && model_ready(ch);
        for (int i = 0; i < CH; i++) begin
            if (en[i]) begin
                if (wave_q[i].size() == 0)
                    for (int k = 0; k < int'(m_ap[i]); k++) wave_q[i].push_back(k < int'(m_ah[i]));
                o[i] = wave_q[i].pop_front();
                if (wave_q[i].size() == 0 && m_pend[i]) begin
                    m_ap[i] = m_sp[i]; m_ah[i] = m_sh[i]; m_pend[i] = 1'b0;
                end
            end else begin
                wave_q[i].delete();
                o[i] = 1'b0;
                if (m_pend[i]) begin
                    m_ap[i] = m_sp[i]; m_ah[i] = m_sh[i]; m_pend[i] = 1'b0;
                end
            end
            t[i] = o[i] & ~m_prev[i];
            m_prev[i] = o[i];
        end
        if (acc && ch < CH) begin
            m_sp[ch] = (p < 2) ? W'(2) : W'(p);
            m_sh[ch] = W'(h);
            m_pend[ch] = 1'b1;
        end
`ifdef PROG_CLK_DIV_TICK_EN
        exp_q.push_back({t, o});
`else
        exp_q.push_back({{CH{1'b0}}, o});
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, check ready, then check outputs.
    task automatic step(input logic [CH-1:0] en, input logic v, input int ch,
                        input int p, input int h);
        logic [2*CH-1:0] e;
        enable     = en;
        cfg_valid  = v;
        cfg_chan   = ch[1:0];
        cfg_period = p[W-1:0];
        cfg_high   = h[W-1:0];
        #1;
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, model_ready(ch)});
        model_edge(en, v, ch, p, h);
        @(negedge clock_in);
        e = exp_q.pop_front();
        check("clock_out", {28'd0, clock_out}, {28'd0, e[CH-1:0]});
        check("tick", {28'd0, tick}, {28'd0, e[2*CH-1:CH]});
    endtask

    task automatic run(input logic [CH-1:0] en, input int n, input int c, output logic [31:0] bits);
        bits = '0;
        for (int k = 0; k < n; k++) begin
            step(en, 1'b0, 0, 0, 0);
            bits = {bits[30:0], clock_out[c]};
        end
    endtask

    logic [31:0] bits;
    logic [CH-1:0] ren;

    initial begin
        reset_n = 1'b0; enable = '0; cfg_valid = 1'b0; cfg_chan = '0;
        cfg_period = '0; cfg_high = '0;
        model_reset();
        repeat (2) @(negedge clock_in);
        check("reset_clock_out", {28'd0, clock_out}, 32'd0);
        check("reset_tick", {28'd0, tick}, 32'd0);
        check("reset_ready", {31'd0, cfg_ready}, 32'd1);
        reset_n = 1'b1;

        // Channel 0 on defaults
        run(4'b0001, 4, 0, bits);
        check("ch0_default", bits, 32'b1010);

        // ch1 P=5 H=2 while disabled, then run
        step(4'b0001, 1'b1, 1, 5, 2);
        step(4'b0001, 1'b0, 1, 0, 0);
        run(4'b0011, 10, 1, bits);
        check("ch1_p5h2", bits, 32'b1100011000);

        // Mid-period rewrite of ch1: current period completes before P=3 H=1
        bits = '0;
        for (int k = 0; k < 11; k++) begin
            step(4'b0011, (k == 2), 1, 3, 1);
            bits = {bits[30:0], clock_out[1]};
            if (k == 2) begin
                cfg_valid = 1'b0; cfg_chan = 2'd1;
                #1 check("ch1_busy_ready", {31'd0, cfg_ready}, 32'd0);
            end
        end
        check("ch1_reconfig", bits, 32'b11000100100);

        // Corner values on ch2
        step(4'b0011, 1'b1, 2, 0, 1);
        step(4'b0011, 1'b0, 2, 0, 0);
        run(4'b0111, 4, 2, bits);
        check("ch2_p0", bits, 32'b1010);
        step(4'b0011, 1'b1, 2, 4, 0);
        step(4'b0011, 1'b0, 2, 0, 0);
        run(4'b0111, 8, 2, bits);
        check("ch2_h0", bits, 32'd0);
        step(4'b0011, 1'b1, 2, 4, 7);
        step(4'b0011, 1'b0, 2, 0, 0);
        run(4'b0111, 8, 2, bits);
        check("ch2_h7", bits, 32'hff);

        // Busy ch1 stalls while idle ch3 accepts immediately
        step(4'b0111, 1'b1, 1, 6, 2);
        cfg_valid = 1'b1; cfg_chan = 2'd1;
        #1 check("stall_ready_ch1", {31'd0, cfg_ready}, 32'd0);
        step(4'b0111, 1'b1, 1, 9, 9);
        cfg_chan = 2'd3;
        #1 check("idle_ready_ch3", {31'd0, cfg_ready}, 32'd1);
        step(4'b0111, 1'b1, 3, 4, 2);
        run(4'b1111, 12, 3, bits);

        // Asynchronous reset in a high phase with a pending write
        step(4'b0110, 1'b1, 0, 6, 3);
        step(4'b0110, 1'b0, 0, 0, 0);
        step(4'b0111, 1'b0, 0, 0, 0);
        step(4'b0111, 1'b1, 0, 2, 1);
        check("pre_reset_high", {31'd0, clock_out[0]}, 32'd1);
        cfg_valid = 1'b0; cfg_chan = 2'd0;
        #2 reset_n = 1'b0;
        #1;
        check("async_clock_out", {28'd0, clock_out}, 32'd0);
        check("async_tick", {28'd0, tick}, 32'd0);
        check("async_ready", {31'd0, cfg_ready}, 32'd1);
        model_reset();
        @(negedge clock_in);
        reset_n = 1'b1;
        run(4'b0001, 4, 0, bits);
        check("post_reset_ch0", bits, 32'b1010);

        // Randomized traffic
        ren = 4'b1111;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 15) == 0) ren[i] = ~ren[i];
            step(ren, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 13)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
